pipelined_cla_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/pipelined_cla_adder_if.sv | 28 ++
 rtl/pipelined_cla_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// master = producer of operands and consumer of results; slave = the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA add/sub: one WIDTH/STAGES segment per stage, latency STAGES, one beat/cycle.
// Backpressure: a stalled output freezes every stage; in_ready is combinational from the output side.
module pipelined_cla_adder #(
    parameter int WIDTH      = 32,
    parameter int GROUP_SIZE = 4,
    parameter int STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP_SIZE;

    logic w_adv;

    // Returns {carry_out, sum} of one segment using group generate/propagate lookahead.
    function automatic logic [SEG:0] seg_cla(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] c;
        logic [NGRP:0]  gc;
        logic           gg;
        logic           pg;
        logic           cc;
        p     = a ^ b;
        g     = a & b;
        c     = '0;
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            pg = 1'b1;
            for (int i = 0; i < GROUP_SIZE; i++) begin
                gg = g[j*GROUP_SIZE+i] | (p[j*GROUP_SIZE+i] & gg);
                pg = pg & p[j*GROUP_SIZE+i];
            end
            gc[j+1] = gg | (pg & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            cc = gc[j];
            for (int i = 0; i < GROUP_SIZE; i++) begin
                c[j*GROUP_SIZE+i] = cc;
                cc = g[j*GROUP_SIZE+i] | (p[j*GROUP_SIZE+i] & cc);
            end
        end
        return {gc[NGRP], p ^ c};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * SEG;
        localparam int UPW = WIDTH - LO;

        logic [UPW-1:0]    w_a;
        logic [UPW-1:0]    w_b;
        logic              w_ci;
        logic              w_vin;
        logic [SEG:0]      w_r;
        logic [LO+SEG-1:0] w_s;
        logic              r_vld;
        logic              r_c;
        logic [LO+SEG-1:0] r_s;

        if (k == 0) begin : g_head
            // in_ready equals w_adv, so any in_valid seen while shifting is an accepted beat.
            assign w_vin = bus.in_valid;
            assign w_a   = bus.in_a;
            assign w_b   = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign w_ci  = bus.in_sub ^ bus.in_cin;
            assign w_s   = w_r[SEG-1:0];
        end else begin : g_body
            assign w_vin = g_stg[k-1].r_vld;
            assign w_a   = g_stg[k-1].g_fwd.r_a;
            assign w_b   = g_stg[k-1].g_fwd.r_b;
            assign w_ci  = g_stg[k-1].r_c;
            assign w_s   = {w_r[SEG-1:0], g_stg[k-1].r_s};
        end

        assign w_r = seg_cla(w_a[SEG-1:0], w_b[SEG-1:0], w_ci);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_r[SEG];
                r_s   <= w_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UPW-SEG-1:0] r_a;
            logic [UPW-SEG-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[UPW-1:SEG];
                    r_b <= w_b[UPW-1:SEG];
                end
            end
        end else begin : g_last
            logic w_cmsb;
            logic r_ovf;
            logic r_zero;

            // Carry into the MSB recovered from its sum bit and propagate term.
            assign w_cmsb = w_r[SEG-1] ^ w_a[SEG-1] ^ w_b[SEG-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= w_cmsb ^ w_r[SEG];
                    r_zero <= ~|w_s;
                end
            end
        end
    end

    assign w_adv         = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stg[STAGES-1].r_vld;
    assign bus.out_sum   = g_stg[STAGES-1].r_s;
    assign bus.out_cout  = g_stg[STAGES-1].r_c;
    assign bus.out_ovf   = g_stg[STAGES-1].g_last.r_ovf;
    assign bus.out_zero  = g_stg[STAGES-1].g_last.r_zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench: 8-bit/2-stage instance for directed vectors, 32-bit/4-stage instance for a random stream.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(8))  b8 ();
    pipelined_cla_adder_if #(.WIDTH(32)) b32 ();

    pipelined_cla_adder #(.WIDTH(8),  .GROUP_SIZE(4), .STAGES(2)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    pipelined_cla_adder #(.WIDTH(32), .GROUP_SIZE(4), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    res_t       q8[$];
    res_t       q32[$];
    logic [7:0] rxlog8[$];
    int         rx32   = 0;
    logic       hold8  = 1'b0;
    logic       hold32 = 1'b0;
    res_t       ph8;
    res_t       ph32;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_res(input string tag, input res_t act, input res_t exp);
        chk({tag, "_sum"},  64'(act.sum),  64'(exp.sum));
        chk({tag, "_cout"}, 64'(act.cout), 64'(exp.cout));
        chk({tag, "_ovf"},  64'(act.ovf),  64'(exp.ovf));
        chk({tag, "_zero"}, 64'(act.zero), 64'(exp.zero));
    endtask

    // Reference from plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub);
        res_t   r;
        longint m, ua, ub, sa, sb, ci, u, s;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        ci = cin ? 1 : 0;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!sub) begin
            u      = ua + ub + ci;
            s      = sa + sb + ci;
            r.cout = (u >= m);
        end else begin
            u      = ua - ub - ci;
            s      = sa - sb - ci;
            r.cout = (u >= 0);
        end
        r.sum  = 32'(u & (m - 1));
        r.ovf  = (s < -(m / 2)) || (s >= m / 2);
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    always @(negedge clk) begin : compare
        res_t o8;
        res_t o32;
        res_t e;
        o8  = '{sum: {24'd0, b8.out_sum}, cout: b8.out_cout, ovf: b8.out_ovf, zero: b8.out_zero};
        o32 = '{sum: b32.out_sum, cout: b32.out_cout, ovf: b32.out_ovf, zero: b32.out_zero};
        if (rst) begin
            q8.delete();
            q32.delete();
            hold8  = 1'b0;
            hold32 = 1'b0;
        end else begin
            if (hold8) begin
                chk("hold8_vld", 64'(b8.out_valid), 64'd1);
                chk_res("hold8", o8, ph8);
            end
            if (b8.out_valid && b8.out_ready) begin
                chk("beat8_expected", 64'(q8.size() != 0), 64'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk_res("beat8", o8, e);
                    rxlog8.push_back(b8.out_sum);
                end
            end
            if (b8.in_valid && b8.in_ready)
                q8.push_back(ref_calc(8, {24'd0, b8.in_a}, {24'd0, b8.in_b}, b8.in_cin, b8.in_sub));
            hold8 = b8.out_valid && !b8.out_ready;
            ph8   = o8;

            if (hold32) begin
                chk("hold32_vld", 64'(b32.out_valid), 64'd1);
                chk_res("hold32", o32, ph32);
            end
            if (b32.out_valid && b32.out_ready) begin
                chk("beat32_expected", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk_res("beat32", o32, e);
                    rx32++;
                end
            end
            if (b32.in_valid && b32.in_ready)
                q32.push_back(ref_calc(32, b32.in_a, b32.in_b, b32.in_cin, b32.in_sub));
            hold32 = b32.out_valid && !b32.out_ready;
            ph32   = o32;
        end
    end

    // Single beat into an empty pipe; checks exact latency and literal results.
    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                            input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        b8.in_a     = a;
        b8.in_b     = b;
        b8.in_cin   = cin;
        b8.in_sub   = sub;
        b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        chk("lat_not_early", 64'(b8.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_vld",  64'(b8.out_valid), 64'd1);
        chk("lit_sum",  64'(b8.out_sum),   64'(es));
        chk("lit_cout", 64'(b8.out_cout),  64'(ec));
        chk("lit_ovf",  64'(b8.out_ovf),   64'(eo));
        chk("lit_zero", 64'(b8.out_zero),  64'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        int   idx;
        int   sent;
        logic acc;

        rst           = 1'b1;
        b8.in_valid   = 1'b1;
        b8.in_a       = 8'h55;
        b8.in_b       = 8'h22;
        b8.in_cin     = 1'b0;
        b8.in_sub     = 1'b0;
        b8.out_ready  = 1'b1;
        b32.in_valid  = 1'b0;
        b32.in_a      = '0;
        b32.in_b      = '0;
        b32.in_cin    = 1'b0;
        b32.in_sub    = 1'b0;
        b32.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        b8.in_valid = 1'b0;
        chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_in_ready",  64'(b8.in_ready),  64'd1);
        chk("rst_out_sum",   64'(b8.out_sum),   64'd0);
        chk("rst_out_cout",  64'(b8.out_cout),  64'd0);
        chk("rst_out_ovf",   64'(b8.out_ovf),   64'd0);
        chk("rst_out_zero",  64'(b8.out_zero),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_ghost", 64'(b8.out_valid), 64'd0);

        send_one(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send_one(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        send_one(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        send_one(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        send_one(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        send_one(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Stream with a three-cycle output stall.
        rxlog8.delete();
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            b8.out_ready = !(cyc >= 3 && cyc <= 5);
            b8.in_valid  = (idx < 6);
            b8.in_a      = 8'(8'h10 + idx);
            b8.in_b      = 8'h20;
            b8.in_cin    = 1'b0;
            b8.in_sub    = 1'b0;
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5)
                chk("stall_in_ready", 64'(b8.in_ready), 64'd0);
            acc = b8.in_valid && b8.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        chk("stream_count", 64'(rxlog8.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < rxlog8.size())
                chk("stream_order", 64'(rxlog8[i]), 64'(8'h30 + i));

        // Reset with two beats in flight.
        b8.out_ready = 1'b0;
        b8.in_sub    = 1'b0;
        b8.in_a      = 8'h01;
        b8.in_b      = 8'h01;
        b8.in_valid  = 1'b1;
        @(posedge clk); #1;
        b8.in_a = 8'h02;
        b8.in_b = 8'h02;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        chk("preflush_vld", 64'(b8.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        b8.out_ready = 1'b1;
        chk("flush_vld", 64'(b8.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("flush_no_beat", 64'(b8.out_valid), 64'd0);
        end
        send_one(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);

        // Random stream on the 32-bit, 4-stage instance.
        sent = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            b32.in_valid  = ($urandom_range(0, 3) != 0);
            b32.in_a      = $urandom;
            b32.in_b      = (cyc % 97 == 0) ? b32.in_a : $urandom;
            b32.in_cin    = 1'($urandom_range(0, 1));
            b32.in_sub    = 1'($urandom_range(0, 1));
            b32.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (b32.in_valid && b32.in_ready) sent++;
            @(posedge clk); #1;
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_count",  64'(rx32), 64'(sent));
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained",  64'(q8.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
